// File: rtl/gmii_arb_pkg.sv
// Shared types and defaults for the two-source GMII transmit arbiter.
// Holds the FSM state encoding, the source index type and the default timing constants.
package gmii_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        XMIT     = 2'd2,
        IFG      = 2'd3
    } arb_state_e;

    typedef logic src_idx_t;

    localparam src_idx_t SRC0 = 1'b0;
    localparam src_idx_t SRC1 = 1'b1;

    localparam int DEF_IFG_CYCLES = 12;
    localparam int DEF_START_TMO  = 64;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gmii_tx_arbiter.sv
// Round-robin arbiter that lets an ARP source and a UDP source share one GMII
// transmit path, enforcing an inter-frame gap and a start-of-frame timeout.
module gmii_tx_arbiter
    import gmii_arb_pkg::*;
#(
    parameter int IFG_CYCLES = DEF_IFG_CYCLES,
    parameter int START_TMO  = DEF_START_TMO
) (
    input  logic       gmii_tx_clk,
    input  logic       reset,
    input  logic       src0_req,
    output logic       src0_gnt,
    input  logic       src0_tx_en,
    input  logic [7:0] src0_txd,
    input  logic       src1_req,
    output logic       src1_gnt,
    input  logic       src1_tx_en,
    input  logic [7:0] src1_txd,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       busy
);

    localparam int CNT_MAX = max_int(IFG_CYCLES, START_TMO);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(START_TMO - 1);

    arb_state_e       state_q;
    src_idx_t         gnt_idx_q;
    src_idx_t         last_served_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tx_en_q;
    logic [7:0]       txd_q;

    logic             sel_req;
    logic             sel_tx_en;
    logic [7:0]       sel_txd;
    logic             tx_en_d;
    logic [7:0]       txd_d;
    src_idx_t         winner_d;
    logic [CNT_W-1:0] cnt_inc_d;

    // Only the granted source is ever looked at; the other one is fully masked.
    always_comb begin
        sel_req   = src0_req;
        sel_tx_en = src0_tx_en;
        sel_txd   = src0_txd;
        if (gnt_idx_q == SRC1) begin
            sel_req   = src1_req;
            sel_tx_en = src1_tx_en;
            sel_txd   = src1_txd;
        end
        tx_en_d = (gnt0_q | gnt1_q) & sel_tx_en;
        txd_d   = tx_en_d ? sel_txd : 8'h00;
    end

    always_comb begin
        winner_d = SRC0;
        if (src0_req && src1_req) begin
            winner_d = ~last_served_q;
        end else if (src1_req) begin
            winner_d = SRC1;
        end
        cnt_inc_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_idx_q     <= SRC0;
            last_served_q <= SRC1;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            cnt_q         <= '0;
            tx_en_q       <= 1'b0;
            txd_q         <= 8'h00;
        end else begin
            tx_en_q <= tx_en_d;
            txd_q   <= txd_d;
            case (state_q)
                IDLE: begin
                    if (src0_req || src1_req) begin
                        state_q   <= WAIT_SOF;
                        gnt_idx_q <= winner_d;
                        gnt0_q    <= (winner_d == SRC0);
                        gnt1_q    <= (winner_d == SRC1);
                        cnt_q     <= '0;
                    end
                end
                WAIT_SOF: begin
                    if (sel_tx_en) begin
                        state_q       <= XMIT;
                        last_served_q <= gnt_idx_q;
                    end else if (!sel_req || cnt_q == TMO_LAST) begin
                        // Withdrawal or a stalled source: release without a gap.
                        state_q       <= IDLE;
                        gnt0_q        <= 1'b0;
                        gnt1_q        <= 1'b0;
                        last_served_q <= gnt_idx_q;
                        cnt_q         <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                XMIT: begin
                    if (!sel_tx_en) begin
                        state_q       <= IFG;
                        gnt0_q        <= 1'b0;
                        gnt1_q        <= 1'b0;
                        last_served_q <= gnt_idx_q;
                        cnt_q         <= '0;
                    end
                end
                IFG: begin
                    if (cnt_q == IFG_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                end
            endcase
        end
    end

    assign src0_gnt   = gnt0_q;
    assign src1_gnt   = gnt1_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_txd   = txd_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed self-checking bench for gmii_tx_arbiter: one task per scenario,
// outputs sampled 1 ns after each rising clock edge.
module tb_gmii_tx_arbiter;

    localparam int IFG = 12;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       src0_req = 1'b0;
    logic       src0_gnt;
    logic       src0_tx_en = 1'b0;
    logic [7:0] src0_txd = 8'h00;
    logic       src1_req = 1'b0;
    logic       src1_gnt;
    logic       src1_tx_en = 1'b0;
    logic [7:0] src1_txd = 8'h00;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #4 clk = ~clk;

    gmii_tx_arbiter #(
        .IFG_CYCLES(IFG),
        .START_TMO (TMO)
    ) dut (
        .gmii_tx_clk(clk),
        .reset      (reset),
        .src0_req   (src0_req),
        .src0_gnt   (src0_gnt),
        .src0_tx_en (src0_tx_en),
        .src0_txd   (src0_txd),
        .src1_req   (src1_req),
        .src1_gnt   (src1_gnt),
        .src1_tx_en (src1_tx_en),
        .src1_txd   (src1_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_txd   (gmii_txd),
        .busy       (busy)
    );

    // Length of the most recent run of idle output cycles between two frames.
    int zero_run;
    int last_gap;
    bit seen_frame;
    always @(negedge clk) begin
        if (reset) begin
            zero_run   <= 0;
            last_gap   <= 0;
            seen_frame <= 1'b0;
        end else if (gmii_tx_en) begin
            if (seen_frame && zero_run > 0) last_gap <= zero_run;
            zero_run   <= 0;
            seen_frame <= 1'b1;
        end else begin
            zero_run <= zero_run + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        src0_req   = 1'b0;
        src1_req   = 1'b0;
        src0_tx_en = 1'b0;
        src1_tx_en = 1'b0;
        src0_txd   = 8'h00;
        src1_txd   = 8'h00;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Drives one frame from a granted source, checking every output byte and the gnt release.
    task automatic drive_frame(input int src, input int len, input logic [7:0] base,
                               input bit drop_req, input string tag);
        logic got_gnt;
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = base + 8'(i);
            if (src == 0) begin src0_tx_en = 1'b1; src0_txd = b; end
            else          begin src1_tx_en = 1'b1; src1_txd = b; end
            tick;
            n_cmp++;
            if (gmii_tx_en !== 1'b1 || gmii_txd !== b) begin
                n_err++;
                $display("FAIL %s byte %0d: got en=%b txd=%02h, want en=1 txd=%02h",
                         tag, i, gmii_tx_en, gmii_txd, b);
            end
        end
        if (src == 0) begin
            src0_tx_en = 1'b0; src0_txd = 8'h00;
            if (drop_req) src0_req = 1'b0;
        end else begin
            src1_tx_en = 1'b0; src1_txd = 8'h00;
            if (drop_req) src1_req = 1'b0;
        end
        tick;
        got_gnt = (src == 0) ? src0_gnt : src1_gnt;
        n_cmp++;
        if (got_gnt !== 1'b0 || gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00) begin
            n_err++;
            $display("FAIL %s eof: got gnt=%b en=%b txd=%02h, want gnt=0 en=0 txd=00",
                     tag, got_gnt, gmii_tx_en, gmii_txd);
        end
    endtask

    task automatic wait_gnt(input int src, input int budget, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick;
            waited++;
            if ((src == 0 && src0_gnt === 1'b1) || (src == 1 && src1_gnt === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        n_cmp++;
        if (src0_gnt !== 1'b0 || src1_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_gnt: got %b%b, want 00", src0_gnt, src1_gnt);
        end
        n_cmp++;
        if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00) begin
            n_err++;
            $display("FAIL reset_out: got en=%b txd=%02h, want en=0 txd=00", gmii_tx_en, gmii_txd);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b, want 0", busy);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single;
        do_reset;
        src0_req = 1'b1;
        tick;
        n_cmp++;
        if (src0_gnt !== 1'b1 || src1_gnt !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_gnt: got gnt0=%b gnt1=%b busy=%b, want 1 0 1",
                     src0_gnt, src1_gnt, busy);
        end
        drive_frame(0, 64, 8'h00, 1'b1, "single");
        repeat (IFG - 1) tick;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_ifg_hold: got busy=%b, want 1", busy);
        end
        tick;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_ifg_end: got busy=%b, want 0", busy);
        end
        $display("single: 64-byte frame from src0 done");
    endtask

    task automatic test_tie;
        int waited;
        bit ok;
        do_reset;
        src0_req = 1'b1;
        src1_req = 1'b1;
        tick;
        n_cmp++;
        if (src0_gnt !== 1'b1 || src1_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL tie_first: got gnt0=%b gnt1=%b, want 1 0", src0_gnt, src1_gnt);
        end
        drive_frame(0, 8, 8'hA0, 1'b1, "tie_src0");
        wait_gnt(1, 40, waited, ok);
        n_cmp++;
        if (!ok || waited != IFG + 1) begin
            n_err++;
            $display("FAIL tie_second_gnt: got ok=%b after %0d cycles, want ok=1 after %0d",
                     ok, waited, IFG + 1);
        end
        drive_frame(1, 8, 8'h50, 1'b1, "tie_src1");
        n_cmp++;
        if (last_gap < IFG) begin
            n_err++;
            $display("FAIL tie_gap: got %0d idle cycles, want >= %0d", last_gap, IFG);
        end
        repeat (IFG + 2) tick;
        $display("tie: src0 then src1, gap %0d cycles", last_gap);
    endtask

    task automatic test_fairness;
        bit ok;
        int who;
        do_reset;
        src0_req = 1'b1;
        src1_req = 1'b1;
        for (int f = 0; f < 6; f++) begin
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                tick;
                if (src0_gnt === 1'b1 || src1_gnt === 1'b1) begin ok = 1'b1; break; end
            end
            who = (src1_gnt === 1'b1) ? 1 : 0;
            n_cmp++;
            if (!ok || who != (f % 2) || (src0_gnt === 1'b1 && src1_gnt === 1'b1)) begin
                n_err++;
                $display("FAIL fair_grant %0d: got ok=%b gnt0=%b gnt1=%b, want src%0d",
                         f, ok, src0_gnt, src1_gnt, f % 2);
            end
            if (!ok) break;
            drive_frame(who, 4, 8'h30 + 8'(f * 16), 1'b0, "fair");
            $display("fairness: frame %0d granted to src%0d", f, who);
        end
        src0_req = 1'b0;
        src1_req = 1'b0;
        repeat (IFG + 4) tick;
    endtask

    task automatic test_timeout;
        int hold;
        bit any_tx;
        do_reset;
        src1_req = 1'b1;
        tick;
        n_cmp++;
        if (src1_gnt !== 1'b1 || src0_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_gnt1: got gnt0=%b gnt1=%b, want 0 1", src0_gnt, src1_gnt);
        end
        src0_req = 1'b1;
        hold   = 1;
        any_tx = gmii_tx_en;
        for (int k = 0; k < 200; k++) begin
            tick;
            any_tx |= gmii_tx_en;
            if (src1_gnt !== 1'b1) break;
            hold++;
        end
        n_cmp++;
        if (hold != TMO) begin
            n_err++;
            $display("FAIL tmo_hold: got gnt1 high %0d cycles, want %0d", hold, TMO);
        end
        tick;
        any_tx |= gmii_tx_en;
        n_cmp++;
        if (src0_gnt !== 1'b1 || src1_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_next: got gnt0=%b gnt1=%b, want 1 0", src0_gnt, src1_gnt);
        end
        n_cmp++;
        if (any_tx !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_quiet: got gmii_tx_en pulse=%b, want 0", any_tx);
        end
        src0_req = 1'b0;
        src1_req = 1'b0;
        tick;
        tick;
        $display("timeout: src1 released after %0d cycles", hold);
    endtask

    task automatic test_illegal;
        bit leak;
        do_reset;
        src0_req   = 1'b1;
        src1_tx_en = 1'b1;
        src1_txd   = 8'hEE;
        tick;
        n_cmp++;
        if (src0_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_gnt: got gnt0=%b, want 1", src0_gnt);
        end
        drive_frame(0, 6, 8'h10, 1'b1, "illegal");
        leak = 1'b0;
        src0_tx_en = 1'b1;
        src0_txd   = 8'h77;
        repeat (3) begin
            tick;
            leak |= gmii_tx_en;
        end
        n_cmp++;
        if (leak !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_ifg_leak: got gmii_tx_en=%b, want 0", leak);
        end
        src0_tx_en = 1'b0;
        src0_txd   = 8'h00;
        src1_tx_en = 1'b0;
        src1_txd   = 8'h00;
        repeat (IFG + 2) tick;
        $display("illegal: src1 and late src0 tx_en masked");
    endtask

    task automatic test_abort;
        do_reset;
        src0_req = 1'b1;
        tick;
        src0_tx_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            src0_txd = 8'(i + 1);
            tick;
        end
        n_cmp++;
        if (gmii_tx_en !== 1'b1 || gmii_txd !== 8'h05) begin
            n_err++;
            $display("FAIL abort_midframe: got en=%b txd=%02h, want en=1 txd=05", gmii_tx_en, gmii_txd);
        end
        reset    = 1'b1;
        src0_txd = 8'h99;
        tick;
        n_cmp++;
        if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00 || src0_gnt !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset: got en=%b txd=%02h gnt0=%b busy=%b, want 0 00 0 0",
                     gmii_tx_en, gmii_txd, src0_gnt, busy);
        end
        reset      = 1'b0;
        src0_req   = 1'b0;
        src0_tx_en = 1'b0;
        src0_txd   = 8'h00;
        src1_req   = 1'b1;
        tick;
        n_cmp++;
        if (src1_gnt !== 1'b1 || src0_gnt !== 1'b0 || gmii_tx_en !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_ifg: got gnt1=%b gnt0=%b en=%b, want 1 0 0",
                     src1_gnt, src0_gnt, gmii_tx_en);
        end
        src1_req = 1'b0;
        tick;
        tick;
        $display("abort: reset mid-frame cleared outputs");
    endtask

    task automatic test_withdraw;
        do_reset;
        src0_req = 1'b1;
        tick;
        n_cmp++;
        if (src0_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL wd_gnt0: got %b, want 1", src0_gnt);
        end
        src0_req = 1'b0;
        src1_req = 1'b1;
        tick;
        n_cmp++;
        if (src0_gnt !== 1'b0 || src1_gnt !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL wd_idle: got gnt0=%b gnt1=%b busy=%b, want 0 0 0", src0_gnt, src1_gnt, busy);
        end
        tick;
        n_cmp++;
        if (src1_gnt !== 1'b1 || src0_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL wd_gnt1: got gnt0=%b gnt1=%b, want 0 1", src0_gnt, src1_gnt);
        end
        src1_req = 1'b0;
        tick;
        tick;
        $display("withdraw: src1 granted one cycle after src0 withdrew");
    endtask

    initial begin
        test_reset;
        test_single;
        test_tie;
        test_fairness;
        test_timeout;
        test_illegal;
        test_abort;
        test_withdraw;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gmii_tx_arbiter.md
GMII_TX_ARBITER -- requirements
Module: gmii_tx_arbiter

Interface
REQ-001 The block SHALL have parameter IFG_CYCLES, default 12: minimum number of idle gmii_tx_en=0 cycles between frames at the output.
REQ-002 The block SHALL have parameter START_TMO, default 64: maximum number of cycles a granted source may hold the grant without starting a frame.
REQ-003 The block SHALL have port gmii_tx_clk, input, 1 bit: the single clock for all logic (the 125 MHz GMII transmit clock).
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port src0_req, input, 1 bit: source 0 (ARP) requests the transmit path.
REQ-006 The block SHALL have port src0_gnt, output, 1 bit: source 0 currently owns the transmit path.
REQ-007 The block SHALL have ports src0_tx_en, input, 1 bit, and src0_txd, input, 8 bits: source 0 GMII transmit enable and data.
REQ-008 The block SHALL have ports src1_req, src1_gnt, src1_tx_en and src1_txd[7:0], defined as in REQ-005 to REQ-007, for source 1 (UDP).
REQ-009 The block SHALL have ports gmii_tx_en, output, 1 bit, and gmii_txd, output, 8 bits: the arbitrated GMII stream to the RGMII transmit path.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state machine is not in IDLE.

Function
REQ-011 The state machine SHALL have four states: IDLE, WAIT_SOF, XMIT and IFG.
REQ-012 In IDLE, when any request is high, the block SHALL select a winner and move to WAIT_SOF; the winner's gnt SHALL rise on the next clock edge.
REQ-013 Arbitration SHALL be round-robin:
- with one request, that source wins;
- with both requests, the source not recorded in last_served wins.
REQ-014 last_served SHALL be updated to the granted source on every exit from WAIT_SOF or XMIT.
REQ-015 The gnt outputs SHALL be registered and mutually exclusive.
REQ-016 gnt SHALL be high exactly while the state is WAIT_SOF or XMIT.
REQ-017 In WAIT_SOF:
- granted tx_en=1: go to XMIT;
- granted req=0 before tx_en: go to IDLE with no gap;
- START_TMO cycles elapsed without tx_en: go to IDLE and drop gnt.
REQ-018 In XMIT, the first cycle with granted tx_en=0 SHALL mark end of frame.
- go to IFG and drop gnt;
- any later tx_en pulse from that source SHALL be ignored.
REQ-019 The output path SHALL be registered with 1-cycle latency.
- gmii_tx_en(n+1) = granted tx_en(n) while gnt is high, else 0;
- gmii_txd(n+1) = granted txd(n) when that tx_en is 1, else 8'h00.
REQ-020 tx_en and txd of a non-granted source SHALL never reach the outputs.
REQ-021 IFG SHALL hold for IFG_CYCLES cycles, then go to IDLE.
- Measured at the outputs, the gap between the last gmii_tx_en=1 of one frame and the first gmii_tx_en=1 of the next SHALL be at least IFG_CYCLES zero cycles.
REQ-022 Requests arriving during IFG SHALL be held pending and arbitrated on entry to IDLE.
REQ-023 The IFG and timeout counters SHALL be sized to hold max(IFG_CYCLES, START_TMO) and SHALL saturate, never wrap.

Reset
REQ-024 On reset, the block SHALL apply the following on the next edge, including during a frame:
- state = IDLE, both gnt = 0, gmii_tx_en = 0, gmii_txd = 8'h00, busy = 0;
- last_served = source 1, so source 0 wins the first tie;
- counters = 0.
REQ-025 A frame cut off by reset SHALL NOT resume; no IFG SHALL be enforced after reset.

Structure
REQ-026 A shared package gmii_arb_pkg SHALL hold:
- the state enum;
- default constants for IFG_CYCLES (12) and START_TMO (64);
- the source-index type.
REQ-027 The block SHALL be a single module with no sub-modules; the two-way round-robin is too small to split out.

Verification
REQ-028 Single source: src0_req=1 and a 64-byte frame 0x00..0x3F → src0_gnt rises 1 cycle after req; gmii_txd is the source data delayed 1 cycle; gnt drops the cycle after tx_en falls.
REQ-029 Tie: both req=1 after reset → src0 is served first, then src1; there are ≥12 zero cycles of gmii_tx_en between the frames; src1 data is never corrupted.
REQ-030 Fairness: both sources request continuously for 6 frames → grants alternate 0,1,0,1,0,1.
REQ-031 Timeout: src1 granted and never asserts tx_en → src1_gnt drops after 64 cycles; a pending src0 is granted next; gmii_tx_en stays 0 throughout.
REQ-032 Illegal/abort: src1_tx_en asserted while src0 is granted → outputs show src0 only. reset pulse mid-frame → next cycle gmii_tx_en=0, gnt=0, busy=0.
REQ-033 Withdrawal: src0_req drops in WAIT_SOF → IDLE with no IFG; a src1 request is granted 1 cycle later.
